// File: rtl/md_unit_param.sv
// rtl/md_unit_param.sv - parametrised multiply/divide unit with HI/LO, per-op latency and cancel
module md_unit_param #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cancel,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT - 1);
  localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT - 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d, divz_q, divz_d;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   a_mag, b_mag, b_safe, b_mag_safe;
  logic [WIDTH-1:0]   uq, ur, sq, sr, dq, dr;
  logic               a_neg, b_neg;

  // Signed divide works on magnitudes so the most-negative / -1 case wraps back to A with remainder 0.
  always_comb begin
    prod_u     = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    prod_s     = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    a_neg      = a_q[WIDTH-1];
    b_neg      = b_q[WIDTH-1];
    a_mag      = a_neg ? -a_q : a_q;
    b_mag      = b_neg ? -b_q : b_q;
    b_safe     = (b_q == '0) ? WIDTH'(1) : b_q;
    b_mag_safe = (b_q == '0) ? WIDTH'(1) : b_mag;
    uq         = a_mag / b_mag_safe;
    ur         = a_mag % b_mag_safe;
    sq         = (a_neg ^ b_neg) ? -uq : uq;
    sr         = a_neg ? -ur : ur;
    dq         = a_q / b_safe;
    dr         = a_q % b_safe;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    divz_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start && !Cancel) begin
          case (Op)
            OP_MULT, OP_MULTU: begin
              op_d = Op; a_d = A; b_d = B; cnt_d = MULT_CNT; state_d = RUN;
            end
            OP_DIV, OP_DIVU: begin
              op_d = Op; a_d = A; b_d = B; cnt_d = DIV_CNT; state_d = RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (Cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV: begin
              if (b_q == '0) divz_d = 1'b1;
              else begin lo_d = sq; hi_d = sr; end
            end
            OP_DIVU: begin
              if (b_q == '0) divz_d = 1'b1;
              else begin lo_d = dq; hi_d = dr; end
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      divz_q  <= divz_d;
    end
  end

  assign Busy    = (state_q == RUN);
  assign Done    = done_q;
  assign DivZero = divz_q;
  assign HI      = hi_q;
  assign LO      = lo_q;

endmodule

// File: tb/tb_md_unit_param.sv
// tb/tb_md_unit_param.sv - directed bench for md_unit_param (32-bit default and 8-bit single-cycle mult)
module tb_md_unit_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, cancel;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, divz;
  logic [31:0] hi, lo;

  logic        start8, cancel8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, divz8;
  logic [7:0]  hi8, lo8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  md_unit_param dut (
    .Clock(clk), .Reset(rst_n), .Start(start), .Op(op), .A(a), .B(b), .Cancel(cancel),
    .Busy(busy), .Done(done), .DivZero(divz), .HI(hi), .LO(lo)
  );

  md_unit_param #(.WIDTH(8), .MULT_LAT(1), .DIV_LAT(2)) dut8 (
    .Clock(clk), .Reset(rst_n), .Start(start8), .Op(op8), .A(a8), .B(b8), .Cancel(cancel8),
    .Busy(busy8), .Done(done8), .DivZero(divz8), .HI(hi8), .LO(lo8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 0; cancel = 0; op = 0; a = 0; b = 0;
    start8 = 0; cancel8 = 0; op8 = 0; a8 = 0; b8 = 0;
    repeat (2) tick();
    checks++;
    if ({busy, done, divz, hi, lo} !== 67'd0) begin
      errors++; $display("FAIL reset32 got busy=%b done=%b dz=%b hi=%h lo=%h want all 0", busy, done, divz, hi, lo);
    end
    checks++;
    if ({busy8, done8, divz8, hi8, lo8} !== 19'd0) begin
      errors++; $display("FAIL reset8 got busy=%b done=%b hi=%h lo=%h want all 0", busy8, done8, hi8, lo8);
    end
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    int n;
    launch(3'd0, 32'hFFFFFFFD, 32'd7);
    wait_idle(n);
    checks++;
    if (n !== 5) begin errors++; $display("FAIL mult_busy got %0d want 5", n); end
    checks++;
    if (done !== 1'b1 || divz !== 1'b0) begin errors++; $display("FAIL mult_done got done=%b dz=%b want 1 0", done, divz); end
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
      errors++; $display("FAIL mult_res got %h_%h want FFFFFFFF_FFFFFFEB", hi, lo);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_clear got %b want 0", done); end
  endtask

  task automatic test_div();
    int n;
    launch(3'd3, 32'd100, 32'd7);
    wait_idle(n);
    checks++;
    if (n !== 10) begin errors++; $display("FAIL divu_busy got %0d want 10", n); end
    checks++;
    if (lo !== 32'h0000000E || hi !== 32'h00000002 || done !== 1'b1) begin
      errors++; $display("FAIL divu_res got hi=%h lo=%h done=%b want 2 E 1", hi, lo, done);
    end
    tick();
    launch(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    checks++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL div_neg got hi=%h lo=%h want FFFFFFFF FFFFFFFD", hi, lo);
    end
    tick();
  endtask

  task automatic test_divzero();
    int n;
    launch(3'd4, 32'h11, 32'd0);
    checks++;
    if (hi !== 32'h11 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mthi got hi=%h busy=%b done=%b want 11 0 0", hi, busy, done);
    end
    launch(3'd5, 32'h22, 32'd0);
    checks++;
    if (lo !== 32'h22) begin errors++; $display("FAIL mtlo got %h want 22", lo); end
    launch(3'd2, 32'd5, 32'd0);
    wait_idle(n);
    checks++;
    if (n !== 10 || done !== 1'b1 || divz !== 1'b1) begin
      errors++; $display("FAIL divzero_flag got n=%0d done=%b dz=%b want 10 1 1", n, done, divz);
    end
    checks++;
    if (hi !== 32'h11 || lo !== 32'h22) begin errors++; $display("FAIL divzero_keep got %h %h want 11 22", hi, lo); end
    tick();
    checks++;
    if (divz !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL divzero_clear got dz=%b done=%b want 0 0", divz, done); end
  endtask

  task automatic test_cancel();
    logic seen_done;
    launch(3'd0, 32'd3, 32'd4);
    start = 1'b1; op = 3'd5; a = 32'hDEAD;
    tick();
    start = 1'b0;
    checks++;
    if (lo !== 32'h22 || busy !== 1'b1) begin errors++; $display("FAIL mtlo_busy got lo=%h busy=%b want 22 1", lo, busy); end
    tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL cancel got busy=%b done=%b want 0 0", busy, done); end
    seen_done = 1'b0;
    repeat (6) begin tick(); seen_done |= done; end
    checks++;
    if (seen_done !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) begin
      errors++; $display("FAIL cancel_keep got done=%b hi=%h lo=%h want 0 11 22", seen_done, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    launch(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    checks++;
    if (lo !== 32'h80000000 || hi !== 32'h0 || divz !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL div_ovf got hi=%h lo=%h dz=%b done=%b want 0 80000000 0 1", hi, lo, divz, done);
    end
    launch(3'd1, 32'd2, 32'd3);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", busy); end
    wait_idle(n);
    checks++;
    if (n !== 5 || hi !== 32'h0 || lo !== 32'h6) begin
      errors++; $display("FAIL b2b_res got n=%0d hi=%h lo=%h want 5 0 6", n, hi, lo);
    end
    tick();
  endtask

  task automatic test_async_reset();
    int n;
    launch(3'd3, 32'd50, 32'd5);
    tick();
    tick();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || done !== 1'b0) begin
      errors++; $display("FAIL async_reset got busy=%b hi=%h lo=%h done=%b want 0 0 0 0", busy, hi, lo, done);
    end
    #2 rst_n = 1'b1;
    tick();
    repeat (12) tick();
    checks++;
    if (done !== 1'b0 || lo !== 32'h0) begin errors++; $display("FAIL reset_nocommit got done=%b lo=%h want 0 0", done, lo); end
    start8 = 1'b1; op8 = 3'd0; a8 = 8'h80; b8 = 8'hFF;
    tick();
    start8 = 1'b0;
    n = 0;
    while (busy8 && n < 20) begin tick(); n++; end
    checks++;
    if (n !== 1 || done8 !== 1'b1 || hi8 !== 8'h00 || lo8 !== 8'h80) begin
      errors++; $display("FAIL mult8 got n=%0d done=%b hi=%h lo=%h want 1 1 00 80", n, done8, hi8, lo8);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_divzero();
    test_cancel();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
